// File: rtl/z80_io_ports.sv
// Z80-side I/O port decoder: command/reply latch strobes, command NMI and
// the four ROM bank registers that form the banked M1-ROM address.
module z80_io_ports (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic [15:0] SDA,
  input  logic        nSDW,
  output logic        nSDZ80R,
  output logic        nSDZ80W,
  output logic        nSDZ80CLR,
  output logic        nNMI,
  output logic [4:0]  BANK0,
  output logic [5:0]  BANK1,
  output logic [6:0]  BANK2,
  output logic [7:0]  BANK3,
  output logic [18:0] SDRA
);

  logic io_rd, io_wr, access, access_q, start;
  logic port_cmd, port_bank, port_reply;
  logic sdw_s1, sdw_s2, sdw_q, sdw_rise;
  logic nmi_en, nmi_pend, nmi_off;

  always_comb begin
    io_rd      = ~nIORQ & nM1 & ~nRD;
    io_wr      = ~nIORQ & nM1 & ~nWR;
    access     = io_rd | io_wr;
    start      = access & ~access_q;
    port_cmd   = (SDA[3:2] == 2'b00);
    port_bank  = (SDA[3:2] == 2'b10);
    port_reply = (SDA[3:2] == 2'b11);
    sdw_rise   = sdw_s2 & ~sdw_q;
    nmi_off    = start & io_wr & port_bank & SDA[4];
  end

  // access_q resets high so an access spanning reset release is not a new start
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      access_q  <= 1'b1;
      nSDZ80R   <= 1'b1;
      nSDZ80W   <= 1'b1;
      nSDZ80CLR <= 1'b1;
      nNMI      <= 1'b1;
      sdw_s1    <= 1'b1;
      sdw_s2    <= 1'b1;
      sdw_q     <= 1'b1;
      nmi_en    <= 1'b0;
      nmi_pend  <= 1'b0;
      BANK0     <= 5'h02;
      BANK1     <= 6'h06;
      BANK2     <= 7'h0E;
      BANK3     <= 8'h1E;
    end else begin
      access_q  <= access;
      nSDZ80R   <= ~(io_rd & port_cmd & (start | ~nSDZ80R));
      nSDZ80W   <= ~(io_wr & port_reply & (start | ~nSDZ80W));
      nSDZ80CLR <= ~(start & io_wr & port_cmd);
      sdw_s1    <= nSDW;
      sdw_s2    <= sdw_s1;
      sdw_q     <= sdw_s2;
      nNMI      <= ~nmi_pend;

      if (start & io_wr & port_bank)
        nmi_en <= ~SDA[4];

      // disable beats a new command, a new command beats the read-clear
      if (nmi_off)
        nmi_pend <= 1'b0;
      else if (sdw_rise & nmi_en)
        nmi_pend <= 1'b1;
      else if (start & io_rd & port_cmd)
        nmi_pend <= 1'b0;

      if (start & io_rd & port_bank) begin
        case (SDA[1:0])
          2'd3:    BANK0 <= SDA[12:8];
          2'd2:    BANK1 <= SDA[13:8];
          2'd1:    BANK2 <= SDA[14:8];
          default: BANK3 <= SDA[15:8];
        endcase
      end
    end
  end

  always_comb begin
    if (!SDA[15])      SDRA = {4'b0, SDA[14:0]};
    else if (!SDA[14]) SDRA = {BANK0, SDA[13:0]};
    else if (!SDA[13]) SDRA = {BANK1, SDA[12:0]};
    else if (!SDA[12]) SDRA = {BANK2, SDA[11:0]};
    else if (!SDA[11]) SDRA = {BANK3, SDA[10:0]};
    else               SDRA = '0;
  end

endmodule

// File: tb/tb_z80_io_ports.sv
// Directed bench for z80_io_ports with a queue of expected values.
module tb_z80_io_ports;

  logic        CLK = 1'b0;
  logic        nRESET, nIORQ, nRD, nWR, nM1, nSDW;
  logic [15:0] SDA;
  logic        nSDZ80R, nSDZ80W, nSDZ80CLR, nNMI;
  logic [4:0]  BANK0;
  logic [5:0]  BANK1;
  logic [6:0]  BANK2;
  logic [7:0]  BANK3;
  logic [18:0] SDRA;

  z80_io_ports dut (
    .CLK(CLK), .nRESET(nRESET), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .SDA(SDA), .nSDW(nSDW), .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W),
    .nSDZ80CLR(nSDZ80CLR), .nNMI(nNMI), .BANK0(BANK0), .BANK1(BANK1),
    .BANK2(BANK2), .BANK3(BANK3), .SDRA(SDRA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed %h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_idle();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic bus_io(input logic [15:0] a, input bit rd);
    SDA = a; nM1 = 1'b1; nIORQ = 1'b0;
    if (rd) nRD = 1'b0; else nWR = 1'b0;
  endtask

  // complete I/O access of n cycles followed by idle time
  task automatic io(input logic [15:0] a, input bit rd, input int n);
    bus_io(a, rd); step(n); bus_idle(); step(2);
  endtask

  task automatic sdw_pulse();
    nSDW = 1'b0; step(5); nSDW = 1'b1;
  endtask

  int lat, lows, rises, ack_lows;
  logic prev;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nRESET = 1'b0; nSDW = 1'b1; SDA = '0; bus_idle();
    step(2);
    expect_val("rst_nSDZ80R", 1); chk(nSDZ80R);
    expect_val("rst_nSDZ80W", 1); chk(nSDZ80W);
    expect_val("rst_nSDZ80CLR", 1); chk(nSDZ80CLR);
    expect_val("rst_nNMI", 1); chk(nNMI);
    expect_val("rst_banks", {5'h02, 6'h06, 7'h0E, 8'h1E});
    chk({BANK0, BANK1, BANK2, BANK3});
    SDA = 16'hF123; #1;
    expect_val("rst_sdra", 19'h0F123); chk(SDRA);

    // reset asserted during a command read
    step(1); nRESET = 1'b1;
    step(1); bus_io(16'h0000, 1);
    step(1);
    expect_val("cmd_rd_low", 0); chk(nSDZ80R);
    #2 nRESET = 1'b0; #1;
    expect_val("rst_mid_nSDZ80R", 1); chk(nSDZ80R);
    step(1); nRESET = 1'b1;
    step(3);
    expect_val("no_start_after_rst", 1); chk(nSDZ80R);
    bus_idle(); step(2);

    // NMI enabled, latency from nSDW rising edge
    io(16'h0008, 0, 2);
    sdw_pulse();
    expect_val("nmi_idle_during_sdw_low", 1); chk(nNMI);
    lat = 0;
    while (nNMI !== 1'b0 && lat < 8) begin step(1); lat++; end
    expect_val("nmi_latency_3to4", 1); chk(32'(lat >= 3 && lat <= 4));

    // command read clears the NMI
    bus_io(16'h0000, 1);
    step(1);
    expect_val("cmd_rd_c1", 0); chk(nSDZ80R);
    step(1);
    expect_val("nmi_cleared_by_read", 1); chk(nNMI);
    expect_val("cmd_rd_c2", 0); chk(nSDZ80R);
    step(1);
    expect_val("cmd_rd_c3", 0); chk(nSDZ80R);
    bus_idle(); step(1);
    expect_val("cmd_rd_release", 1); chk(nSDZ80R);
    step(2);

    // new command edge coincides with the read access start: set wins
    nSDW = 1'b0; step(5); nSDW = 1'b1;
    step(2); bus_io(16'h0000, 1);
    step(3); bus_idle(); step(3);
    expect_val("race_nmi_kept", 0); chk(nNMI);
    io(16'h0000, 1, 2); step(1);
    expect_val("race_followup_clear", 1); chk(nNMI);

    // disable on the same cycle as a set: disable wins
    nSDW = 1'b0; step(5); nSDW = 1'b1;
    step(2); bus_io(16'h0018, 0);
    step(2); bus_idle(); step(4);
    expect_val("disable_beats_set", 1); chk(nNMI);

    // NMI disabled: command edge ignored, enabling later raises nothing
    io(16'h0018, 0, 2);
    sdw_pulse();
    lows = 0;
    for (int i = 0; i < 8; i++) begin step(1); if (nNMI === 1'b0) lows++; end
    expect_val("nmi_disabled_no_low", 0); chk(lows);
    io(16'h0008, 0, 2); step(4);
    expect_val("nmi_enable_late", 1); chk(nNMI);

    // bank switching
    bus_io(16'h3F0B, 1); step(1);
    expect_val("bank0_write", 5'h1F); chk(BANK0);
    step(1); bus_idle(); step(2);
    SDA = 16'h9234; #1;
    expect_val("sdra_bank0", {5'h1F, 14'h1234}); chk(SDRA);
    step(1);
    io(16'hAB08, 1, 2);
    expect_val("bank3_write", 8'hAB); chk(BANK3);
    expect_val("bank12_unchanged", {6'h06, 7'h0E}); chk({BANK1, BANK2});
    SDA = 16'hF7FF; #1;
    expect_val("sdra_bank3_top", {8'hAB, 11'h7FF}); chk(SDRA);
    SDA = 16'hF800; #1;
    expect_val("sdra_wram", 0); chk(SDRA);
    SDA = 16'h7FFF; #1;
    expect_val("sdra_fixed", 19'h07FFF); chk(SDRA);
    SDA = 16'hE456; #1;
    expect_val("sdra_bank2", {7'h0E, 12'h456}); chk(SDRA);
    step(1);

    // reply write: 4 low cycles, single rising edge
    bus_io(16'h000C, 0);
    lows = 0; rises = 0; prev = nSDZ80W;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      if (nSDZ80W === 1'b0) lows++;
      if (prev === 1'b0 && nSDZ80W === 1'b1) rises++;
      prev = nSDZ80W;
      if (i == 4) bus_idle();
    end
    expect_val("reply_low_cycles", 4); chk(lows);
    expect_val("reply_rises", 1); chk(rises);

    // command write: one single-cycle clear pulse
    bus_io(16'h0000, 0);
    lows = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (nSDZ80CLR === 1'b0) lows++;
      if (i == 3) bus_idle();
    end
    expect_val("clr_pulse_cycles", 1); chk(lows);

    // interrupt acknowledge must produce no strobes
    ack_lows = 0;
    SDA = 16'h0000; nIORQ = 1'b0; nM1 = 1'b0; nRD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (nSDZ80R === 1'b0 || nSDZ80CLR === 1'b0 || nSDZ80W === 1'b0) ack_lows++;
    end
    nRD = 1'b1; nWR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (nSDZ80R === 1'b0 || nSDZ80CLR === 1'b0 || nSDZ80W === 1'b0) ack_lows++;
    end
    bus_idle(); step(2);
    expect_val("intack_no_strobes", 0); chk(ack_lows);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
